// File: rtl/shift_pkg.sv
// Shared types and carry helper for the pipelined shift/rotate unit.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_SAR = 3'b100
    } op_t;

    // Widest operand the carry helper can index; data and shamt widths follow WIDTH,
    // so the stage record keeps them as separate width-dependent vectors beside this.
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic valid;
        op_t  op;
        logic carry;
    } stage_ctrl_t;

    // Last bit leaving the word for a total shift of s; zero for s == 0 and PASS ops.
    function automatic logic carry_out(input op_t op, input logic [MAX_WIDTH-1:0] data,
                                       input int width, input int s);
        logic c;
        c = 1'b0;
        if (s != 0) begin
            for (int i = 0; i < MAX_WIDTH; i++) begin
                if ((op == OP_ROL || op == OP_SHL) && i == width - s)
                    c = data[i];
                if ((op == OP_ROR || op == OP_SHR || op == OP_SAR) && i == s - 1)
                    c = data[i];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log-stage of the shifter: conditional 2^K shift/rotate followed by an enabled register.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  stage_ctrl_t                in_ctrl,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    output stage_ctrl_t                out_ctrl,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH)-1:0]   out_shamt
);

    localparam int D = 1 << K;

    logic [WIDTH-1:0] shifted;

    // SAR replicates the current MSB, which still equals the original sign bit.
    always_comb begin
        shifted = in_data;
        if (in_shamt[K]) begin
            case (in_ctrl.op)
                OP_ROL:  shifted = {in_data[WIDTH-D-1:0], in_data[WIDTH-1:WIDTH-D]};
                OP_ROR:  shifted = {in_data[D-1:0], in_data[WIDTH-1:D]};
                OP_SHL:  shifted = {in_data[WIDTH-D-1:0], {D{1'b0}}};
                OP_SHR:  shifted = {{D{1'b0}}, in_data[WIDTH-1:D]};
                OP_SAR:  shifted = {{D{in_data[WIDTH-1]}}, in_data[WIDTH-1:D]};
                default: shifted = in_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ctrl  <= '0;
            out_data  <= '0;
            out_shamt <= '0;
        end else if (en) begin
            out_ctrl  <= in_ctrl;
            out_data  <= shifted;
            out_shamt <= in_shamt;
        end
    end

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit: one register per shift-amount bit, global stall on backpressure.
module shift_rotate_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    stage_ctrl_t      s_ctrl  [0:SHW];
    logic [WIDTH-1:0] s_data  [0:SHW];
    logic [SHW-1:0]   s_shamt [0:SHW];

    stage_ctrl_t            in_ctrl;
    logic [MAX_WIDTH-1:0]   data_ext;
    logic                   en;
    logic                   unused_tail;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Carry is fixed at acceptance from the untouched operand.
    always_comb begin
        data_ext              = '0;
        data_ext[WIDTH-1:0]   = in_data;
        in_ctrl.valid         = in_valid;
        in_ctrl.op            = op_t'(in_op);
        in_ctrl.carry         = carry_out(op_t'(in_op), data_ext, WIDTH, int'(in_shamt));
    end

    assign s_ctrl[0]  = in_ctrl;
    assign s_data[0]  = in_data;
    assign s_shamt[0] = in_shamt;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_ctrl   (s_ctrl[k]),
            .in_data   (s_data[k]),
            .in_shamt  (s_shamt[k]),
            .out_ctrl  (s_ctrl[k+1]),
            .out_data  (s_data[k+1]),
            .out_shamt (s_shamt[k+1])
        );
    end

    assign out_valid = s_ctrl[SHW].valid;
    assign out_data  = s_data[SHW];
    assign out_carry = s_ctrl[SHW].carry;
    assign out_zero  = (s_data[SHW] == '0);

    assign unused_tail = ^{s_shamt[SHW], s_ctrl[SHW].op};

endmodule
